and_gate: RTL and testbench
===========================

AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1: bit width of operands A, B and result Y.
REQ-002 Parameter CNT_W, default 8: width of each combination-occurrence counter.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port A  input  WIDTH: operand A.
REQ-006 Port B  input  WIDTH: operand B.
REQ-007 Port Y  output  WIDTH: combinational bitwise AND of A and B.
REQ-008 Port in_valid  input  1: qualifies A/B for registered path and counters.
REQ-009 Port clr  input  1: synchronous clear of counters and registered outputs.
REQ-010 Port y_q  output  WIDTH: registered A&B.
REQ-011 Port out_valid  output  1: y_q holds a result captured from a valid input.
REQ-012 Port all_ones  output  1: registered reduction-AND of y_q contents (1 when every bit of the captured result is 1).
REQ-013 Port cnt00, cnt01, cnt10, cnt11  output  CNT_W each: count of valid samples where {A[0],B[0]} equals 00, 01, 10, 11.

Function
REQ-014 Y SHALL equal A & B bit-for-bit at all times, including while rst_n is low and when clk is not toggling.
REQ-015 Y SHALL settle within the same delta/timestep as an input change; no clock dependency.
REQ-016 Truth table per bit: 0&0=0, 0&1=0, 1&0=0, 1&1=1.
REQ-017 On a rising clk edge with in_valid=1 and clr=0: y_q <= A&B, all_ones <= &(A&B), out_valid <= 1 (latency 1 cycle).
REQ-018 On a rising clk edge with in_valid=0 and clr=0: y_q and all_ones SHALL hold; out_valid <= 0.
REQ-019 On a valid sample, exactly one of cnt00..cnt11 selected by {A[0],B[0]} SHALL increment by 1.
REQ-020 Counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-021 clr=1 on a rising edge SHALL zero y_q, all_ones, out_valid and all counters; clr takes priority over in_valid (the concurrent sample is discarded, not counted).
REQ-022 X/Z on A or B SHALL NOT be treated as valid data by the block; behaviour with unknown inputs is unspecified beyond Y = A & B under standard 4-state semantics.

Reset
REQ-023 rst_n low SHALL immediately (asynchronously) force y_q=0, all_ones=0, out_valid=0, cnt00..cnt11=0.
REQ-024 While rst_n is low, registered state SHALL hold reset values regardless of clk, in_valid, clr; Y remains combinational.
REQ-025 Reset deassertion SHALL be glitch-free with respect to clk; first capture occurs on the first rising edge after rst_n goes high.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight result; out_valid drops the same timestep.

Verification
REQ-027 Combinational truth table, WIDTH=1, no clock: (A,B)=(0,0),(0,1),(1,0),(1,1) each held 10 time units -> Y=0,0,0,1.
REQ-028 Registered path: reset, then in_valid=1 with A=1,B=1 for one edge -> next cycle y_q=1, all_ones=1, out_valid=1, cnt11=1; following edge with in_valid=0 -> out_valid=0, y_q=1 held.
REQ-029 Counter sweep: 4 valid cycles with (A,B)=00,01,10,11 -> cnt00=cnt01=cnt10=cnt11=1; repeat 300 cycles of 11 with CNT_W=8 -> cnt11=255 (saturated).
REQ-030 Clear priority: clr=1 and in_valid=1 same edge with A=B=1 -> y_q=0, out_valid=0, all counters 0.
REQ-031 Async reset: drive rst_n low between clock edges after valid captures -> y_q, out_valid, counters 0 without a clock edge; Y still equals A&B.
REQ-032 WIDTH=4: A=4'b1100, B=4'b1010 valid -> Y=4'b1000, y_q=4'b1000 next cycle, all_ones=0; A=B=4'b1111 -> all_ones=1.

Source files
------------

// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate: operands and qualifiers in, combinational
// and registered results plus per-combination occurrence counters out.
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic             in_valid;
  logic             clr;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic             all_ones;
  logic [CNT_W-1:0] cnt00;
  logic [CNT_W-1:0] cnt01;
  logic [CNT_W-1:0] cnt10;
  logic [CNT_W-1:0] cnt11;

  modport master (
    output A, B, in_valid, clr,
    input  Y, y_q, out_valid, all_ones, cnt00, cnt01, cnt10, cnt11
  );

  modport slave (
    input  A, B, in_valid, clr,
    output Y, y_q, out_valid, all_ones, cnt00, cnt01, cnt10, cnt11
  );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND with a combinational output, a one-cycle registered copy of
// valid samples, and saturating counters of the {A[0],B[0]} combinations seen.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  and_gate_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] and_w;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y_q_r;
  logic             all_ones_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] cnt_r [4];

  // Y stays purely combinational so it tracks A/B during reset and with no clock.
  assign and_w  = bus.A & bus.B;
  assign bus.Y  = and_w;
  assign sel    = {bus.A[0], bus.B[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r       <= '0;
      all_ones_r  <= 1'b0;
      out_valid_r <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt_r[i] <= '0;
    end else if (bus.clr) begin
      // Clear wins over a concurrent valid sample; that sample is not counted.
      y_q_r       <= '0;
      all_ones_r  <= 1'b0;
      out_valid_r <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt_r[i] <= '0;
    end else if (bus.in_valid) begin
      y_q_r       <= and_w;
      all_ones_r  <= &and_w;
      out_valid_r <= 1'b1;
      if (cnt_r[sel] != CNT_MAX) cnt_r[sel] <= cnt_r[sel] + CNT_W'(1);
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.y_q       = y_q_r;
  assign bus.all_ones  = all_ones_r;
  assign bus.out_valid = out_valid_r;
  assign bus.cnt00     = cnt_r[0];
  assign bus.cnt01     = cnt_r[1];
  assign bus.cnt10     = cnt_r[2];
  assign bus.cnt11     = cnt_r[3];

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: WIDTH=1 and WIDTH=4 instances driven with
// directed vectors; a negedge monitor pops expected results when out_valid is seen.
module tb_and_gate;

  typedef struct packed {
    logic [3:0] y;
    logic       all;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c3;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clk_run;
  int   checks;
  int   failures;
  exp_t q1[$];
  exp_t q4[$];
  exp_t m1;
  exp_t m4;

  and_gate_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  and_gate_if #(.WIDTH(4), .CNT_W(8)) if4 ();

  and_gate #(.WIDTH(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  and_gate #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic exp_t upd(input exp_t m, input logic [3:0] y, input logic all,
                               input logic a0, input logic b0);
    exp_t r;
    r     = m;
    r.y   = y;
    r.all = all;
    case ({a0, b0})
      2'b00:   r.c0 = sat(m.c0);
      2'b01:   r.c1 = sat(m.c1);
      2'b10:   r.c2 = sat(m.c2);
      default: r.c3 = sat(m.c3);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m1 = '0;
    m4 = '0;
    q1.delete();
    q4.delete();
  endtask

  task automatic drive(input logic a1, input logic b1, input logic [3:0] a4,
                       input logic [3:0] b4, input logic v, input logic c);
    logic [3:0] y4;
    if1.A = a1; if1.B = b1; if1.in_valid = v; if1.clr = c;
    if4.A = a4; if4.B = b4; if4.in_valid = v; if4.clr = c;
    y4 = a4 & b4;
    if (c) begin
      m1 = '0;
      m4 = '0;
    end else if (v) begin
      m1 = upd(m1, {3'b000, a1 & b1}, a1 & b1, a1, b1);
      m4 = upd(m4, y4, &y4, a4[0], b4[0]);
      q1.push_back(m1);
      q4.push_back(m4);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if1.out_valid === 1'b1) begin
      if (q1.size() == 0) check("mon1_unexpected_valid", 1, 0);
      else begin
        e = q1.pop_front();
        check("mon1_y_q", {31'b0, if1.y_q}, {28'b0, e.y});
        check("mon1_all_ones", {31'b0, if1.all_ones}, {31'b0, e.all});
        check("mon1_cnts", {if1.cnt00, if1.cnt01, if1.cnt10, if1.cnt11},
              {e.c0, e.c1, e.c2, e.c3});
      end
    end
    if (if4.out_valid === 1'b1) begin
      if (q4.size() == 0) check("mon4_unexpected_valid", 1, 0);
      else begin
        e = q4.pop_front();
        check("mon4_y_q", {28'b0, if4.y_q}, {28'b0, e.y});
        check("mon4_all_ones", {31'b0, if4.all_ones}, {31'b0, e.all});
        check("mon4_cnts", {if4.cnt00, if4.cnt01, if4.cnt10, if4.cnt11},
              {e.c0, e.c1, e.c2, e.c3});
      end
    end
  end

  task automatic check_cleared(input string name);
    check({name, "_y_q1"}, {31'b0, if1.y_q}, 0);
    check({name, "_ov1"}, {31'b0, if1.out_valid}, 0);
    check({name, "_all1"}, {31'b0, if1.all_ones}, 0);
    check({name, "_cnt1"}, {if1.cnt00, if1.cnt01, if1.cnt10, if1.cnt11}, 0);
    check({name, "_y_q4"}, {28'b0, if4.y_q}, 0);
    check({name, "_ov4"}, {31'b0, if4.out_valid}, 0);
    check({name, "_cnt4"}, {if4.cnt00, if4.cnt01, if4.cnt10, if4.cnt11}, 0);
  endtask

  initial begin
    logic [3:0] tt_exp;
    checks = 0;
    failures = 0;
    clk_run = 1'b0;
    rst_n = 1'b0;
    model_reset();
    if1.A = 1'b0; if1.B = 1'b0; if1.in_valid = 1'b0; if1.clr = 1'b0;
    if4.A = '0;   if4.B = '0;   if4.in_valid = 1'b0; if4.clr = 1'b0;

    // Combinational truth table with no clock and reset held low.
    tt_exp = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      if1.A = i[1];
      if1.B = i[0];
      #10;
      check("comb_truth_table", {31'b0, if1.Y}, {31'b0, tt_exp[i]});
    end
    if4.A = 4'b1100;
    if4.B = 4'b1010;
    #10;
    check("comb_w4", {28'b0, if4.Y}, 32'h8);
    check_cleared("reset_state");

    // Clock runs with in_valid high but reset low: state must stay cleared.
    if1.A = 1'b1; if1.B = 1'b1; if1.in_valid = 1'b1;
    if4.in_valid = 1'b1;
    clk_run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_held");
    @(negedge clk);
    if1.in_valid = 1'b0;
    if4.in_valid = 1'b0;
    rst_n = 1'b1;

    // Single capture then hold.
    drive(1, 1, 4'b0001, 4'b0001, 1, 0);
    check("cap_y_q", {31'b0, if1.y_q}, 1);
    check("cap_all_ones", {31'b0, if1.all_ones}, 1);
    check("cap_out_valid", {31'b0, if1.out_valid}, 1);
    check("cap_cnt11", {24'b0, if1.cnt11}, 1);
    drive(0, 0, 4'b0000, 4'b0000, 0, 0);
    check("hold_out_valid", {31'b0, if1.out_valid}, 0);
    check("hold_y_q", {31'b0, if1.y_q}, 1);
    check("hold_all_ones", {31'b0, if1.all_ones}, 1);

    // Clear, then counter sweep and saturation.
    drive(0, 0, 4'b0000, 4'b0000, 0, 1);
    check_cleared("clr");
    for (int i = 0; i < 4; i++)
      drive(i[1], i[0], {3'b000, i[1]}, {3'b000, i[0]}, 1, 0);
    check("sweep_cnts", {if1.cnt00, if1.cnt01, if1.cnt10, if1.cnt11}, 32'h01010101);
    check("sweep_cnts4", {if4.cnt00, if4.cnt01, if4.cnt10, if4.cnt11}, 32'h01010101);
    repeat (300) drive(1, 1, 4'b1111, 4'b1111, 1, 0);
    check("sat_cnts", {if1.cnt00, if1.cnt01, if1.cnt10, if1.cnt11}, 32'h010101FF);
    check("sat_cnt11_w4", {24'b0, if4.cnt11}, 255);
    check("sat_all_ones_w4", {31'b0, if4.all_ones}, 1);

    // Clear beats a concurrent valid sample.
    drive(1, 1, 4'b1111, 4'b1111, 1, 1);
    check_cleared("clr_priority");

    // WIDTH=4 vectors.
    drive(0, 1, 4'b1100, 4'b1010, 1, 0);
    check("w4_Y", {28'b0, if4.Y}, 32'h8);
    check("w4_y_q", {28'b0, if4.y_q}, 32'h8);
    check("w4_all_ones", {31'b0, if4.all_ones}, 0);
    drive(1, 1, 4'b1111, 4'b1111, 1, 0);
    check("w4_ones_y_q", {28'b0, if4.y_q}, 32'hF);
    check("w4_ones_all", {31'b0, if4.all_ones}, 1);

    // Asynchronous reset between edges after a valid capture.
    drive(1, 1, 4'b0110, 4'b0011, 1, 0);
    check("pre_rst_ov", {31'b0, if1.out_valid}, 1);
    check("pre_rst_y_q4", {28'b0, if4.y_q}, 32'h2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_cleared("async_rst");
    check("async_rst_Y1", {31'b0, if1.Y}, 1);
    check("async_rst_Y4", {28'b0, if4.Y}, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    check_cleared("async_rst_held");
    @(negedge clk);
    if1.in_valid = 1'b0;
    if4.in_valid = 1'b0;
    rst_n = 1'b1;

    drive(1, 0, 4'b0101, 4'b1110, 1, 0);
    check("post_rst_cnt10", {24'b0, if1.cnt10}, 1);
    check("post_rst_y_q4", {28'b0, if4.y_q}, 32'h4);
    drive(0, 0, 4'b0000, 4'b0000, 0, 0);
    drive(0, 0, 4'b0000, 4'b0000, 0, 0);
    check("queue1_drained", q1.size(), 0);
    check("queue4_drained", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
